fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Dual-issue fetch sequencer in front of the two-port asynchronous instruction memory. Owns the program counter and drives both memory address ports with consecutive words (PC, PC+4). Captures the returned instruction pair into a small circular instruction queue and presents the two oldest entries to decode/issue with a consume-count handshake. Handles branch redirects (flush and refetch) and halt.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `QDEPTH`, 4: queue entries; power of two, ≥2.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_addr1` out 32: byte address of slot-0 word (= PC).
- `imem_addr2` out 32: byte address of slot-1 word (= PC+4).
- `imem_instr1` in 32: word at `imem_addr1`, same-cycle (combinational memory).
- `imem_instr2` in 32: word at `imem_addr2`, same-cycle.
- `redirect_valid` in 1: taken branch/jump resolved; flush and refetch.
- `redirect_pc` in 32: new fetch target; bits [1:0] ignored (forced 00).
- `halt` in 1: level; suppress fetch while high.
- `deq_cnt` in 2: entries consumed by issue this cycle (0, 1, 2).
- `out_valid` out 2: bit0 = entry 0 valid, bit1 = entry 1 valid.
- `out_instr0`, `out_instr1` out 32: oldest / second-oldest queued instruction.
- `out_pc0`, `out_pc1` out 32: PCs of those instructions.
- `fetch_state` out 2: current FSM state (encoding from package).

## Operation
- Queue holds {pc, instr} entries; `count` 0..QDEPTH; head/tail pointers wrap modulo QDEPTH.
- Effective pop = min(`deq_cnt`, `count`); `deq_cnt`=3 treated as 2; over-consumption clamped, never underflows.
- Push is all-or-nothing: two entries {PC, imem_instr1}, {PC+4, imem_instr2} when state RUN, no redirect, and `count` − pop ≤ QDEPTH−2 (same-cycle pop counts as freed space). On push PC ← PC+8.
- PC arithmetic is modulo 2^32; PC+4 and PC+8 wrap silently at 32'hFFFF_FFF8/FFFC.
- FSM: RUN (fetching), HOLD (insufficient space), HALTED.
  - RUN → HOLD when push condition fails for space only; HOLD → RUN when space ≥2 after pop.
  - Any state → HALTED when `halt`=1; HALTED → RUN when `halt`=0 (next cycle fetches).
  - Fetch is combinational from state and space, so RUN/HOLD is a label; the push decision is re-evaluated every cycle.
- Redirect has priority over everything: queue flushed (count ← 0), `deq_cnt` ignored, no push that cycle, PC ← {redirect_pc[31:2], 2'b00}. State → RUN unless `halt`, then HALTED.
- Redirect while HALTED: PC and flush still applied.
- `out_valid[0]` = count≥1, `out_valid[1]` = count≥2; data outputs show head and head+1 entries. When an entry is invalid its data is don't-care but stable (no X).
- `imem_addr1/2` always driven from PC, including HALTED/HOLD.

## Timing
- Reset (asynchronous assert, synchronous release usage): PC=RESET_PC, count=0, pointers=0, `out_valid`=00, `out_instr*`=0, `out_pc*`=0, state=RUN, perf counters=0.
- First rising edge after release pushes {RESET_PC, RESET_PC+4}; `out_valid`=11 the following cycle (1-cycle fetch-to-issue latency).
- Redirect at edge N: `out_valid`=00 in cycle N+1; target pair valid in N+2.
- Pop and push in the same cycle both take effect at the same edge.
- Sustained throughput: 2 instructions/cycle when `deq_cnt`=2 every cycle.
- Reset asserted mid-operation: immediate return to reset values; in-flight entries discarded.

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `perf_fetch_pairs` (32, increments per push) and `perf_hold_cycles` (32, increments per cycle in HOLD). Both saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; fetch behaviour identical.

## Structure
- `fetch_pkg`: `fetch_state_t` enum (RUN=0, HOLD=1, HALTED=2), `fetch_entry_t` struct {pc[31:0], instr[31:0]}, `INSTR_BYTES`=4.
- Sub-module `fetch_queue`: parameterised 2-in/2-out circular buffer (push2, pop 0–2, flush, count, head/head+1 read).
- `fetch_ctrl` holds PC, FSM, redirect/halt logic, perf counters.

## Test plan
- Reset, RESET_PC=0, `deq_cnt`=2 always → `out_pc0/1` = 0/4, 8/C, 10/14… on consecutive cycles; `out_valid`=11 from cycle 2.
- `deq_cnt`=0, QDEPTH=4 → two pushes, then state HOLD, count=4, PC=0x10. Set `deq_cnt`=1 → one more cycle held (space 1); second pop → push resumes.
- Redirect to 0x103 with full queue and `deq_cnt`=2 → next cycle `out_valid`=00, then `out_pc0`=0x100, `out_pc1`=0x104.
- `halt`=1 for 3 cycles with `deq_cnt`=1 → queue drains to 0, PC unchanged, state HALTED; release → fetch resumes at held PC.
- `deq_cnt`=2 with count=1 → count 0, no underflow; PC=0xFFFF_FFF8 push → next PC wraps to 0x0.
- With `FETCH_PERF_EN`: 5 pushes and 3 HOLD cycles → counters read 5 and 3; reset clears both.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch sequencer.
package fetch_pkg;

   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      FETCH_RUN    = 2'd0,
      FETCH_HOLD   = 2'd1,
      FETCH_HALTED = 2'd2
   } fetch_state_t;

   localparam logic [1:0] ST_RUN    = FETCH_RUN;
   localparam logic [1:0] ST_HOLD   = FETCH_HOLD;
   localparam logic [1:0] ST_HALTED = FETCH_HALTED;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Issue may request 3; only two entries are ever presented.
   function automatic logic [1:0] clamp_deq(input logic [1:0] d);
      return (d == 2'd3) ? 2'd2 : d;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue: pushes two entries at once, pops 0-2, flushes in one cycle.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      push,
   input  logic [1:0]                pop_cnt,
   input  fetch_entry_t              push0,
   input  fetch_entry_t              push1,
   output logic [$clog2(QDEPTH):0]   count,
   output fetch_entry_t              head0,
   output fetch_entry_t              head1
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t       mem [QDEPTH];
   logic [PW-1:0]      head;
   logic [PW-1:0]      tail;

   // pop_cnt arrives already clamped to count by the controller.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         head  <= tail;
         count <= '0;
      end else begin
         if (push) begin
            mem[tail]            <= push0;
            mem[tail + PW'(1)]   <= push1;
            tail                 <= tail + PW'(2);
         end
         head  <= head + PW'(pop_cnt);
         count <= count + (push ? CW'(2) : CW'(0)) - CW'(pop_cnt);
      end
   end

   assign head0 = mem[head];
   assign head1 = mem[head + PW'(1)];

endmodule

// File: rtl/fetch_ctrl.sv
// Dual-issue fetch sequencer: PC, fetch FSM, redirect/halt handling, instruction queue.
// Optional perf counters are built when FETCH_PERF_EN is defined.
//
// state   | meaning
// RUN     | fetching a pair whenever the queue has room for two
// HOLD    | last cycle had no room for a pair; retried every cycle
// HALTED  | halt asserted; no fetch, queue still drains
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr1,
   output logic [31:0] imem_addr2,
   input  logic [31:0] imem_instr1,
   input  logic [31:0] imem_instr2,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   input  logic [1:0]  deq_cnt,
   output logic [1:0]  out_valid,
   output logic [31:0] out_instr0,
   output logic [31:0] out_instr1,
   output logic [31:0] out_pc0,
   output logic [31:0] out_pc1,
   output logic [1:0]  fetch_state
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_pairs,
   output logic [31:0] perf_hold_cycles
`endif
);

   localparam int CW = $clog2(QDEPTH) + 1;

   logic [31:0]   pc;
   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [CW-1:0] count;
   logic [1:0]    deq_eff;
   logic [1:0]    pop;
   logic [CW-1:0] used_after;
   logic          push;
   fetch_entry_t  push0;
   fetch_entry_t  push1;
   fetch_entry_t  head0;
   fetch_entry_t  head1;
   logic          unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign deq_eff = clamp_deq(deq_cnt);

   // deq_eff > count only happens with count <= 1, so the low bits are exact.
   always_comb begin
      pop = 2'd0;
      if (!redirect_valid) begin
         pop = (CW'(deq_eff) > count) ? count[1:0] : deq_eff;
      end
   end

   // Entries popped this cycle count as free space for this cycle's push.
   assign used_after = count - CW'(pop);
   assign push = !redirect_valid && !halt && (state != ST_HALTED)
              && (used_after <= CW'(QDEPTH - 2));

   always_comb begin
      state_nxt = ST_RUN;
      if (halt) begin
         state_nxt = ST_HALTED;
      end else if (redirect_valid || state == ST_HALTED || push) begin
         state_nxt = ST_RUN;
      end else begin
         state_nxt = ST_HOLD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc    <= RESET_PC;
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
         if (redirect_valid) begin
            pc <= {redirect_pc[31:2], 2'b00};
         end else if (push) begin
            pc <= pc + 32'(2 * INSTR_BYTES);
         end
      end
   end

   assign push0 = '{pc: pc, instr: imem_instr1};
   assign push1 = '{pc: pc + 32'(INSTR_BYTES), instr: imem_instr2};

   fetch_queue #(
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (redirect_valid),
      .push    (push),
      .pop_cnt (pop),
      .push0   (push0),
      .push1   (push1),
      .count   (count),
      .head0   (head0),
      .head1   (head1)
   );

   assign imem_addr1  = pc;
   assign imem_addr2  = pc + 32'(INSTR_BYTES);
   assign out_valid   = {(count >= CW'(2)), (count >= CW'(1))};
   assign out_instr0  = head0.instr;
   assign out_instr1  = head1.instr;
   assign out_pc0     = head0.pc;
   assign out_pc1     = head1.pc;
   assign fetch_state = state;

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_pairs <= '0;
         perf_hold_cycles <= '0;
      end else begin
         if (push && perf_fetch_pairs != '1) begin
            perf_fetch_pairs <= perf_fetch_pairs + 32'd1;
         end
         if (state == ST_HOLD && perf_hold_cycles != '1) begin
            perf_hold_cycles <= perf_hold_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then random
// traffic against a queue-based reference model checked every cycle.
module tb_fetch_ctrl;

   localparam int          QDEPTH   = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr1, imem_addr2, imem_instr1, imem_instr2;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic [1:0]  deq_cnt;
   logic [1:0]  out_valid;
   logic [31:0] out_instr0, out_instr1, out_pc0, out_pc1;
   logic [1:0]  fetch_state;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_pairs, perf_hold_cycles;
`endif

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   assign imem_instr1 = mem_fn(imem_addr1);
   assign imem_instr2 = mem_fn(imem_addr2);

   fetch_ctrl #(
      .RESET_PC (RESET_PC),
      .QDEPTH   (QDEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr1     (imem_addr1),
      .imem_addr2     (imem_addr2),
      .imem_instr1    (imem_instr1),
      .imem_instr2    (imem_instr2),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .deq_cnt        (deq_cnt),
      .out_valid      (out_valid),
      .out_instr0     (out_instr0),
      .out_instr1     (out_instr1),
      .out_pc0        (out_pc0),
      .out_pc1        (out_pc1),
      .fetch_state    (fetch_state)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_pairs (perf_fetch_pairs),
      .perf_hold_cycles (perf_hold_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: queue contents, PC, state (0 run, 1 hold, 2 halted).
   logic [31:0] q_pc[$];
   logic [31:0] q_in[$];
   logic [31:0] m_pc;
   int          m_state;
   logic [31:0] m_pairs, m_hold;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q_pc.delete();
      q_in.delete();
      m_pc    = RESET_PC;
      m_state = 0;
      m_pairs = 0;
      m_hold  = 0;
   endtask

   task automatic model_step();
      int d, p;
      bit pushed;
      pushed = 0;
      if (m_state == 1 && m_hold != 32'hFFFF_FFFF) m_hold++;
      if (redirect_valid) begin
         q_pc.delete();
         q_in.delete();
         m_pc    = {redirect_pc[31:2], 2'b00};
         m_state = halt ? 2 : 0;
      end else begin
         d = (deq_cnt == 2'd3) ? 2 : int'(deq_cnt);
         p = (d < q_pc.size()) ? d : q_pc.size();
         for (int i = 0; i < p; i++) begin
            void'(q_pc.pop_front());
            void'(q_in.pop_front());
         end
         if (!halt && m_state != 2 && q_pc.size() <= QDEPTH - 2) begin
            q_pc.push_back(m_pc);
            q_in.push_back(mem_fn(m_pc));
            q_pc.push_back(m_pc + 32'd4);
            q_in.push_back(mem_fn(m_pc + 32'd4));
            m_pc   = m_pc + 32'd8;
            pushed = 1;
            if (m_pairs != 32'hFFFF_FFFF) m_pairs++;
         end
         if (halt)              m_state = 2;
         else if (m_state == 2) m_state = 0;
         else                   m_state = pushed ? 0 : 1;
      end
   endtask

   task automatic compare_all();
      logic [31:0] v;
      v = {30'b0, (q_pc.size() >= 2), (q_pc.size() >= 1)};
      chk("out_valid", {30'b0, out_valid}, v);
      chk("imem_addr1", imem_addr1, m_pc);
      chk("imem_addr2", imem_addr2, m_pc + 32'd4);
      chk("fetch_state", {30'b0, fetch_state}, 32'(m_state));
      if (q_pc.size() >= 1) begin
         chk("out_pc0", out_pc0, q_pc[0]);
         chk("out_instr0", out_instr0, q_in[0]);
      end
      if (q_pc.size() >= 2) begin
         chk("out_pc1", out_pc1, q_pc[1]);
         chk("out_instr1", out_instr1, q_in[1]);
      end
`ifdef FETCH_PERF_EN
      chk("perf_fetch_pairs", perf_fetch_pairs, m_pairs);
      chk("perf_hold_cycles", perf_hold_cycles, m_hold);
`endif
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt           = 1'b0;
      deq_cnt        = 2'd0;
      repeat (2) @(negedge clk);
      model_reset();
      chk("rst_out_valid", {30'b0, out_valid}, 32'h0);
      chk("rst_out_pc0", out_pc0, 32'h0);
      chk("rst_out_instr0", out_instr0, 32'h0);
      chk("rst_out_instr1", out_instr1, 32'h0);
      chk("rst_state", {30'b0, fetch_state}, 32'h0);
      chk("rst_addr2", imem_addr2, 32'h4);
      compare_all();
      rst_n = 1'b1;

      // Streaming at full consume rate.
      deq_cnt = 2'd2;
      cycle();
      chk("first_valid", {30'b0, out_valid}, 32'h3);
      chk("first_pc0", out_pc0, 32'h0);
      chk("first_pc1", out_pc1, 32'h4);
      cycle();
      chk("second_pc0", out_pc0, 32'h8);
      chk("second_pc1", out_pc1, 32'hC);
      chk("second_addr", imem_addr1, 32'h10);

      // Fill and hold.
      deq_cnt = 2'd0;
      cycle();
      cycle();
      chk("hold_state", {30'b0, fetch_state}, 32'h1);
      chk("hold_addr", imem_addr1, 32'h18);
      deq_cnt = 2'd1;
      cycle();
      chk("hold1_state", {30'b0, fetch_state}, 32'h1);
      chk("hold1_pc0", out_pc0, 32'hC);
      cycle();
      chk("resume_state", {30'b0, fetch_state}, 32'h0);
      chk("resume_addr", imem_addr1, 32'h20);
      chk("resume_pc0", out_pc0, 32'h10);
`ifdef FETCH_PERF_EN
      chk("perf_pairs_lit", perf_fetch_pairs, 32'd4);
      chk("perf_hold_lit", perf_hold_cycles, 32'd2);
`endif

      // Redirect with a full queue.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      deq_cnt        = 2'd2;
      cycle();
      chk("redir_valid", {30'b0, out_valid}, 32'h0);
      chk("redir_addr", imem_addr1, 32'h100);
      redirect_valid = 1'b0;
      deq_cnt        = 2'd0;
      cycle();
      chk("redir_pc0", out_pc0, 32'h100);
      chk("redir_pc1", out_pc1, 32'h104);

      // Halt drains the queue, PC held.
      halt    = 1'b1;
      deq_cnt = 2'd1;
      repeat (3) cycle();
      chk("halt_valid", {30'b0, out_valid}, 32'h0);
      chk("halt_state", {30'b0, fetch_state}, 32'h2);
      chk("halt_addr", imem_addr1, 32'h108);
      halt    = 1'b0;
      deq_cnt = 2'd0;
      cycle();
      chk("unhalt_state", {30'b0, fetch_state}, 32'h0);
      chk("unhalt_valid", {30'b0, out_valid}, 32'h0);
      cycle();
      chk("unhalt_pc0", out_pc0, 32'h108);

      // Over-consumption clamps at empty.
      halt    = 1'b1;
      deq_cnt = 2'd1;
      cycle();
      deq_cnt = 2'd2;
      cycle();
      chk("clamp_valid", {30'b0, out_valid}, 32'h0);
      deq_cnt = 2'd3;
      cycle();
      chk("clamp3_valid", {30'b0, out_valid}, 32'h0);

      // PC wrap at the top of the address space.
      halt           = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      deq_cnt        = 2'd0;
      cycle();
      chk("wrap_addr2", imem_addr2, 32'hFFFF_FFFC);
      redirect_valid = 1'b0;
      cycle();
      chk("wrap_pc1", out_pc1, 32'hFFFF_FFFC);
      chk("wrap_addr", imem_addr1, 32'h0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         deq_cnt        = 2'($urandom_range(0, 3));
         redirect_valid = ($urandom_range(0, 24) == 0);
         redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
         if ($urandom_range(0, 19) == 0) halt = ~halt;
         if (i == 1500) begin
            rst_n = 1'b0;
            #1;
            chk("midrst_valid", {30'b0, out_valid}, 32'h0);
            chk("midrst_addr", imem_addr1, RESET_PC);
            model_reset();
            compare_all();
            #1;
            rst_n = 1'b1;
         end
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
